// File: rtl/cnn_pkg.sv
// Shared types and default widths for the CNN host transfer engine.
package cnn_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 16;

  // Transfer engine session states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_IF = 3'd1,
    S_LOAD_W  = 3'd2,
    S_START   = 3'd3,
    S_WAIT    = 3'd4,
    S_READ    = 3'd5,
    S_FIN     = 3'd6
  } xfer_state_e;

endpackage

// File: rtl/bram_host_xfer_if.sv
// Host stream, core handshake and BRAM port bundle for bram_host_xfer.
interface bram_host_xfer_if
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  // Session control
  logic              go;
  logic              busy;
  logic              err;
  // Load stream
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  // Result stream
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  // Core handshake
  logic              cnn_start;
  logic              cnn_done;
  // IF BRAM write port
  logic [ADDR_W-1:0] bram_if_addr;
  logic              bram_if_en;
  logic              bram_if_we;
  logic [DATA_W-1:0] bram_if_wdata;
  // W BRAM write port
  logic [ADDR_W-1:0] bram_w_addr;
  logic              bram_w_en;
  logic              bram_w_we;
  logic [DATA_W-1:0] bram_w_wdata;
  // TEMP BRAM read port
  logic [ADDR_W-1:0] bram_tmp_addr;
  logic              bram_tmp_en;
  logic [DATA_W-1:0] bram_tmp_rdata;

  // Transfer engine side
  modport master (
    input  go, in_data, in_valid, in_last, out_ready, cnn_done, bram_tmp_rdata,
    output busy, err, in_ready, out_data, out_valid, out_last, cnn_start,
    output bram_if_addr, bram_if_en, bram_if_we, bram_if_wdata,
    output bram_w_addr, bram_w_en, bram_w_we, bram_w_wdata,
    output bram_tmp_addr, bram_tmp_en
  );

  // Host / memory side
  modport slave (
    output go, in_data, in_valid, in_last, out_ready, cnn_done, bram_tmp_rdata,
    input  busy, err, in_ready, out_data, out_valid, out_last, cnn_start,
    input  bram_if_addr, bram_if_en, bram_if_we, bram_if_wdata,
    input  bram_w_addr, bram_w_en, bram_w_we, bram_w_wdata,
    input  bram_tmp_addr, bram_tmp_en
  );

endinterface

// File: rtl/xfer_fifo2.sv
// Two-entry result FIFO with fall-through: a word arriving into an empty
// FIFO is presented the same cycle and is only stored if not taken.
module xfer_fifo2 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic              o_valid_c,
  output logic [DATA_W-1:0] o_data_c,
  output logic [1:0]        o_occ
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_occ;

  logic w_empty;
  logic w_pop;
  logic w_deq;
  logic w_push;

  // Head selection, bypass and push/pop qualification
  always_comb begin
    w_empty   = (r_occ == 2'd0);
    o_valid_c = !w_empty || i_wr_en;
    o_data_c  = '0;
    if (!w_empty) begin
      o_data_c = r_mem[r_rptr];
    end else if (i_wr_en) begin
      o_data_c = i_wr_data;
    end
    w_pop  = i_rd_en && o_valid_c;
    w_deq  = w_pop && !w_empty;
    w_push = i_wr_en && !(w_empty && w_pop);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_deq) begin
        r_rptr <= ~r_rptr;
      end
      r_occ <= r_occ + 2'(w_push) - 2'(w_deq);
    end
  end

  assign o_occ = r_occ;

endmodule

// File: rtl/bram_host_xfer.sv
// Host-side transfer engine: loads IF and W BRAMs from a byte stream, runs
// the CNN core via start/done, then streams the TEMP result region back out.
module bram_host_xfer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned IF_LEN  = 1024,
  parameter int unsigned W_LEN   = 256,
  parameter int unsigned RES_LEN = 294
) (
  input  logic             clk,
  input  logic             rst,
  bram_host_xfer_if.master bus
);

  localparam logic [ADDR_W-1:0] IF_LAST  = ADDR_W'(IF_LEN - 1);
  localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(W_LEN - 1);
  localparam logic [ADDR_W-1:0] RES_LAST = ADDR_W'(RES_LEN - 1);

  xfer_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic              r_rd_done, w_rd_done_nxt;
  logic [ADDR_W-1:0] r_out_cnt, w_out_cnt_nxt;
  logic              r_inflight;

  logic              w_in_ready;
  logic              w_if_wr;
  logic              w_w_wr;
  logic              w_tmp_rd;
  logic              w_start;
  logic              w_fifo_valid;
  logic [DATA_W-1:0] w_fifo_data;
  logic [1:0]        w_fifo_occ;
  logic              w_pop;
  logic [2:0]        w_outstanding;

  // Reads are only issued while stored words plus reads in flight stay below two
  assign w_outstanding = 3'(w_fifo_occ) + 3'(r_inflight);
  assign w_pop         = w_fifo_valid && bus.out_ready;

  xfer_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_inflight),
    .i_wr_data (bus.bram_tmp_rdata),
    .i_rd_en   (bus.out_ready),
    .o_valid_c (w_fifo_valid),
    .o_data_c  (w_fifo_data),
    .o_occ     (w_fifo_occ)
  );

  // Next-state, counter and strobe decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_err_nxt     = r_err;
    w_rd_addr_nxt = r_rd_addr;
    w_rd_done_nxt = r_rd_done;
    w_out_cnt_nxt = r_out_cnt;
    w_in_ready    = 1'b0;
    w_if_wr       = 1'b0;
    w_w_wr        = 1'b0;
    w_tmp_rd      = 1'b0;
    w_start       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.go) begin
          w_state_nxt = S_LOAD_IF;
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end

      S_LOAD_IF: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_if_wr = 1'b1;
          // in_last is only legal on the final W beat
          if (bus.in_last) begin
            w_err_nxt = 1'b1;
          end
          if (r_cnt == IF_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_LOAD_W;
          end else begin
            w_cnt_nxt = r_cnt + ADDR_W'(1);
          end
        end
      end

      S_LOAD_W: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_w_wr = 1'b1;
          if (r_cnt == W_LAST) begin
            if (!bus.in_last) begin
              w_err_nxt = 1'b1;
            end
            w_cnt_nxt   = '0;
            w_state_nxt = S_START;
          end else begin
            if (bus.in_last) begin
              w_err_nxt = 1'b1;
            end
            w_cnt_nxt = r_cnt + ADDR_W'(1);
          end
        end
      end

      S_START: begin
        w_start       = 1'b1;
        w_rd_addr_nxt = '0;
        w_rd_done_nxt = 1'b0;
        w_out_cnt_nxt = '0;
        w_state_nxt   = S_WAIT;
      end

      S_WAIT: begin
        if (bus.cnn_done) begin
          w_state_nxt = S_READ;
        end
      end

      S_READ: begin
        // Separate done flag so RES_LEN == 2**ADDR_W never wraps the address
        if (!r_rd_done && (w_outstanding < 3'd2)) begin
          w_tmp_rd = 1'b1;
          if (r_rd_addr == RES_LAST) begin
            w_rd_done_nxt = 1'b1;
          end else begin
            w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
          end
        end
        if (w_pop) begin
          if (r_out_cnt == RES_LAST) begin
            w_state_nxt = S_FIN;
          end else begin
            w_out_cnt_nxt = r_out_cnt + ADDR_W'(1);
          end
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters, error flag and read-in-flight tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_done  <= 1'b0;
      r_out_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_rd_done  <= w_rd_done_nxt;
      r_out_cnt  <= w_out_cnt_nxt;
      r_inflight <= w_tmp_rd;
    end
  end

  // Port drive; addresses and data are zeroed whenever the port is idle
  always_comb begin
    bus.busy          = (r_state != S_IDLE);
    bus.err           = r_err;
    bus.in_ready      = w_in_ready;
    bus.cnn_start     = w_start;
    bus.bram_if_en    = w_if_wr;
    bus.bram_if_we    = w_if_wr;
    bus.bram_if_addr  = w_if_wr ? r_cnt : '0;
    bus.bram_if_wdata = w_if_wr ? bus.in_data : '0;
    bus.bram_w_en     = w_w_wr;
    bus.bram_w_we     = w_w_wr;
    bus.bram_w_addr   = w_w_wr ? r_cnt : '0;
    bus.bram_w_wdata  = w_w_wr ? bus.in_data : '0;
    bus.bram_tmp_en   = w_tmp_rd;
    bus.bram_tmp_addr = w_tmp_rd ? r_rd_addr : '0;
    bus.out_valid     = w_fifo_valid;
    bus.out_data      = w_fifo_data;
    bus.out_last      = w_fifo_valid && (r_out_cnt == RES_LAST);
  end

endmodule

// File: tb/tb_bram_host_xfer.sv
// Directed bench for bram_host_xfer with small lengths and BRAM models.
module tb_bram_host_xfer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bram_host_xfer_if #(.DATA_W(8), .ADDR_W(16)) bus ();

  bram_host_xfer #(
    .DATA_W (8),
    .ADDR_W (16),
    .IF_LEN (4),
    .W_LEN  (2),
    .RES_LEN(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] if_mem  [16];
  logic [7:0] w_mem   [16];
  logic [7:0] tmp_mem [16];
  logic [3:0] rdy_pat = 4'b1001;

  int n_checks = 0;
  int n_fail   = 0;

  int tmp_rd_cnt  = 0;
  int start_cnt   = 0;
  int gap_wr_cnt  = 0;
  int wr_cnt      = 0;
  int outstanding = 0;
  int max_out     = 0;

  // Memory models: IF/W write ports, TEMP read latency 1
  always @(posedge clk) begin
    if (bus.bram_if_en && bus.bram_if_we) if_mem[bus.bram_if_addr[3:0]] <= bus.bram_if_wdata;
    if (bus.bram_w_en && bus.bram_w_we)   w_mem[bus.bram_w_addr[3:0]]   <= bus.bram_w_wdata;
    if (bus.bram_tmp_en) bus.bram_tmp_rdata <= tmp_mem[bus.bram_tmp_addr[3:0]];
  end

  // Event counters observed at the active edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= 0;
    end else begin
      if (bus.bram_tmp_en) tmp_rd_cnt <= tmp_rd_cnt + 1;
      if (bus.cnn_start) start_cnt <= start_cnt + 1;
      if (bus.bram_if_en || bus.bram_w_en) wr_cnt <= wr_cnt + 1;
      if ((bus.bram_if_en || bus.bram_w_en) && !bus.in_valid) gap_wr_cnt <= gap_wr_cnt + 1;
      outstanding <= outstanding + int'(bus.bram_tmp_en) - int'(bus.out_valid && bus.out_ready);
      if (outstanding > max_out) max_out <= outstanding;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] outs_vec();
    return 128'({bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.err, bus.cnn_start,
                 bus.bram_if_en, bus.bram_if_we, bus.bram_w_en, bus.bram_w_we, bus.bram_tmp_en,
                 bus.bram_if_addr, bus.bram_if_wdata, bus.bram_w_addr, bus.bram_w_wdata,
                 bus.bram_tmp_addr, bus.out_data});
  endfunction

  task automatic pulse_go();
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
  endtask

  // Offer one beat and hold it until accepted; returns 1 time unit after the accepting edge
  task automatic send_beat(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("beat_accept", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Drain RES_LEN beats, checking order, out_last and hold-while-stalled
  task automatic readout(input bit bp, input string nm, output int first_v);
    int got;
    int cyc;
    logic held_v;
    logic [7:0] held_d;
    got = 0; cyc = 0; held_v = 1'b0; held_d = '0; first_v = -1;
    while (got < 3 && cyc < 64) begin
      bus.out_ready = bp ? rdy_pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (bus.out_valid && first_v < 0) first_v = cyc;
      if (held_v) begin
        check_eq({nm, "_hold_valid"}, 128'(bus.out_valid), 128'(1));
        check_eq({nm, "_hold_data"}, 128'(bus.out_data), 128'(held_d));
      end
      if (bus.out_valid && bus.out_ready) begin
        check_eq($sformatf("%s_out%0d", nm, got), 128'(bus.out_data), 128'(8'hA0 + 8'(got)));
        check_eq($sformatf("%s_last%0d", nm, got), 128'(bus.out_last), 128'(got == 2));
        got++;
        held_v = 1'b0;
      end else begin
        held_v = bus.out_valid;
        held_d = bus.out_data;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    check_eq({nm, "_beats"}, 128'(got), 128'(3));
  endtask

  task automatic run_session(input logic [7:0] b_if, input logic [7:0] b_w, input int last_idx,
                             input bit gaps, input bit bp, input bit go_wait, input bit exp_err,
                             input string nm);
    int s0, r0, w0, g0, first;
    s0 = start_cnt; w0 = wr_cnt; g0 = gap_wr_cnt;
    pulse_go();
    @(negedge clk);
    check_eq({nm, "_in_ready"}, 128'(bus.in_ready), 128'(1));
    check_eq({nm, "_busy_on"}, 128'(bus.busy), 128'(1));
    check_eq({nm, "_err_clr"}, 128'(bus.err), 128'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      send_beat((i < 4) ? 8'(b_if + 8'(i)) : 8'(b_w + 8'(i - 4)), 1'(i == last_idx));
      if (gaps && i < 5) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check_eq({nm, "_start"}, 128'(bus.cnn_start), 128'(1));
    check_eq({nm, "_err"}, 128'(bus.err), 128'(exp_err));
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("%s_if%0d", nm, i), 128'(if_mem[i]), 128'(8'(b_if + 8'(i))));
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("%s_w%0d", nm, i), 128'(w_mem[i]), 128'(8'(b_w + 8'(i))));
    check_eq({nm, "_wr_count"}, 128'(wr_cnt - w0), 128'(6));
    check_eq({nm, "_gap_wr"}, 128'(gap_wr_cnt - g0), 128'(0));
    @(posedge clk); #1;
    r0 = tmp_rd_cnt;
    for (int j = 0; j < 5; j++) begin
      bus.go = go_wait && (j == 0);
      @(posedge clk); #1;
      bus.go = 1'b0;
      if (go_wait && j == 0) begin
        @(negedge clk);
        check_eq({nm, "_wait_busy"}, 128'(bus.busy), 128'(1));
        check_eq({nm, "_wait_noready"}, 128'(bus.in_ready), 128'(0));
        check_eq({nm, "_wait_nostart"}, 128'(bus.cnn_start), 128'(0));
      end
    end
    check_eq({nm, "_no_early_rd"}, 128'(tmp_rd_cnt - r0), 128'(0));
    bus.cnn_done = 1'b1;
    @(negedge clk);
    check_eq({nm, "_rd_at_done"}, 128'(bus.bram_tmp_en), 128'(0));
    @(posedge clk); #1;
    bus.cnn_done = 1'b0;
    @(negedge clk);
    check_eq({nm, "_rd_first"}, 128'(bus.bram_tmp_en), 128'(1));
    check_eq({nm, "_rd_addr0"}, 128'(bus.bram_tmp_addr), 128'(0));
    @(posedge clk); #1;
    readout(bp, nm, first);
    check_eq({nm, "_first_valid"}, 128'(first), 128'(0));
    @(negedge clk);
    check_eq({nm, "_busy_fin"}, 128'(bus.busy), 128'(1));
    check_eq({nm, "_no_extra"}, 128'(bus.out_valid), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check_eq({nm, "_busy_off"}, 128'(bus.busy), 128'(0));
    check_eq({nm, "_err_sticky"}, 128'(bus.err), 128'(exp_err));
    check_eq({nm, "_start_cnt"}, 128'(start_cnt - s0), 128'(1));
    check_eq({nm, "_rd_cnt"}, 128'(tmp_rd_cnt - r0), 128'(3));
    check_eq({nm, "_max_out"}, 128'(max_out <= 2), 128'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    bus.go = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
    bus.out_ready = 1'b0; bus.cnn_done = 1'b0;
    tmp_mem[0] = 8'hA0; tmp_mem[1] = 8'hA1; tmp_mem[2] = 8'hA2;
    for (int i = 3; i < 16; i++) tmp_mem[i] = 8'hEE;
    #1;
    check_eq("reset_outs", outs_vec(), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", 128'(bus.busy), 128'(0));
    @(posedge clk); #1;

    // Clean session, full-rate output
    run_session(8'h10, 8'h20, 5, 1'b0, 1'b0, 1'b0, 1'b0, "s1");
    // Early in_last, load gaps, go during WAIT, output backpressure
    run_session(8'h30, 8'h40, 1, 1'b1, 1'b1, 1'b1, 1'b1, "s2");

    // Next go clears err, then reset during LOAD_W
    check_eq("s3_err_idle", 128'(bus.err), 128'(1));
    pulse_go();
    @(negedge clk);
    check_eq("s3_err_clr", 128'(bus.err), 128'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_beat(8'(8'h50 + 8'(i)), 1'b0);
    send_beat(8'h58, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h59;
    rst = 1'b0;
    #1;
    check_eq("s3_rst_outs", outs_vec(), 128'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("s3_idle_busy", 128'(bus.busy), 128'(0));
    check_eq("s3_idle_ready", 128'(bus.in_ready), 128'(0));
    check_eq("s3_w0_partial", 128'(w_mem[0]), 128'(8'h58));
    @(posedge clk); #1;

    // Fresh session after reset
    run_session(8'h10, 8'h20, 5, 1'b0, 1'b0, 1'b0, 1'b0, "s4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
